// File: rtl/logic_pattern_generator.sv
// Pattern playback engine: host-loaded block RAM replayed one word per cap_clk.
// Optional macro PATTERN_GEN_LOOP_FOREVER_EN: repeat_count of all-ones loops until stopped.
module logic_pattern_generator #(
    parameter int PATTERN_WIDTH = 32,
    parameter int PATTERN_DEPTH = 10
) (
    input  logic                     cap_clk,
    input  logic                     rst,
    input  logic                     data_in_write_strobe,
    input  logic [PATTERN_WIDTH-1:0] data_in,
    input  logic                     wr_ptr_reset,
    input  logic [PATTERN_DEPTH:0]   pattern_length,
    input  logic [31:0]              repeat_count,
    input  logic [PATTERN_WIDTH-1:0] idle_value,
    input  logic                     trigger_enable,
    input  logic                     external_trigger,
    input  logic                     start_strobe,
    input  logic                     stop_strobe,
    input  logic                     enable,
    output logic [PATTERN_WIDTH-1:0] pat_data,
    output logic                     pat_valid,
    output logic                     busy,
    output logic                     finished
);
    typedef enum logic [1:0] {IDLE, ARMED, PLAY, DONE} state_t;

    localparam int unsigned          DEPTH_WORDS = 2 ** PATTERN_DEPTH;
    localparam logic [PATTERN_DEPTH:0] MAX_LEN   = (PATTERN_DEPTH + 1)'(DEPTH_WORDS);

    logic [PATTERN_WIDTH-1:0] mem [DEPTH_WORDS];

    state_t                   state;
    logic [PATTERN_DEPTH-1:0] wr_ptr;
    logic [PATTERN_DEPTH-1:0] rd_ptr;
    logic [PATTERN_DEPTH-1:0] last_ptr;
    logic [PATTERN_DEPTH-1:0] len_last;
    logic [31:0]              reps_left;
    logic [PATTERN_WIDTH-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_last;
    logic                     write_ok;
    logic                     at_end;
    logic                     fetch_last;
    logic                     loop_forever;

    // Index of the final word of a pass; lengths beyond the buffer clamp to a full buffer.
    assign len_last = (pattern_length >= MAX_LEN) ? '1
                    : pattern_length[PATTERN_DEPTH-1:0] - PATTERN_DEPTH'(1);

    assign write_ok   = data_in_write_strobe && (state == IDLE);
    assign at_end     = (rd_ptr == last_ptr);
    assign fetch_last = at_end && (reps_left == '0);
    assign busy       = (state != IDLE);

`ifdef PATTERN_GEN_LOOP_FOREVER_EN
    assign loop_forever = (reps_left == '1);
`else
    assign loop_forever = 1'b0;
`endif

    always_ff @(posedge cap_clk) begin
        if (write_ok)
            mem[wr_ptr] <= data_in;
    end

    // Two-stage playback: RAM read into rd_data, then onto pat_data. Both stages
    // stall together on enable=0 so the word stream resumes without a bubble.
    always_ff @(posedge cap_clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_data  <= '0;
            pat_valid <= 1'b0;
            finished  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_ptr  <= '0;
            reps_left <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            finished <= 1'b0;

            if (wr_ptr_reset)
                wr_ptr <= '0;
            else if (write_ok)
                wr_ptr <= wr_ptr + PATTERN_DEPTH'(1);

            case (state)
                IDLE: begin
                    pat_data  <= idle_value;
                    pat_valid <= 1'b0;
                    rd_valid  <= 1'b0;
                    rd_last   <= 1'b0;
                    if (start_strobe && !stop_strobe && (pattern_length != '0)) begin
                        last_ptr  <= len_last;
                        reps_left <= repeat_count;
                        rd_ptr    <= '0;
                        state     <= trigger_enable ? ARMED : PLAY;
                    end
                end
                ARMED: begin
                    pat_valid <= 1'b0;
                    if (stop_strobe)
                        state <= IDLE;
                    else if (external_trigger)
                        state <= PLAY;
                end
                PLAY: begin
                    if (stop_strobe) begin
                        pat_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (enable) begin
                        pat_valid <= rd_valid;
                        if (rd_valid)
                            pat_data <= rd_data;
                        if (rd_valid && rd_last) begin
                            rd_valid <= 1'b0;
                            state    <= DONE;
                        end else begin
                            rd_data  <= mem[rd_ptr];
                            rd_valid <= 1'b1;
                            rd_last  <= fetch_last;
                            if (at_end) begin
                                rd_ptr <= '0;
                                if (!fetch_last && !loop_forever)
                                    reps_left <= reps_left - 32'd1;
                            end else begin
                                rd_ptr <= rd_ptr + PATTERN_DEPTH'(1);
                            end
                        end
                    end else begin
                        pat_valid <= 1'b0;
                    end
                end
                DONE: begin
                    pat_valid <= 1'b0;
                    pat_data  <= idle_value;
                    finished  <= !stop_strobe;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/logic_pattern_generator.md
Name: logic_pattern_generator

Overview:
- Playback counterpart to the capture path. Stores a host-loaded pattern in internal block RAM and replays it, one word per cap_clk, on pat_data.
- Playback starts on software command or on an external trigger. It repeats a programmed number of times.
- Sits beside the logic analyzer inside the wishbone slave. The wrapper drives all control and load ports synchronously to cap_clk.

Parameters:
- PATTERN_WIDTH, 32, width of each pattern word and of pat_data.
- PATTERN_DEPTH, 10, address bits; buffer holds 2^PATTERN_DEPTH words.

Ports:
- cap_clk  input  1  playback clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- data_in_write_strobe  input  1  writes data_in to mem[wr_ptr], then wr_ptr++.
- data_in  input  PATTERN_WIDTH  pattern word to load.
- wr_ptr_reset  input  1  clears wr_ptr to 0.
- pattern_length  input  PATTERN_DEPTH+1  number of words per pass.
- repeat_count  input  32  extra passes after the first.
- idle_value  input  PATTERN_WIDTH  value driven on pat_data when not playing.
- trigger_enable  input  1  when 1, start arms and waits for external_trigger.
- external_trigger  input  1  level-sampled start condition.
- start_strobe  input  1  begins playback.
- stop_strobe  input  1  aborts playback.
- enable  input  1  0 pauses playback in PLAY.
- pat_data  output  PATTERN_WIDTH  registered pattern output.
- pat_valid  output  1  pat_data holds a pattern word this cycle.
- busy  output  1  state != IDLE.
- finished  output  1  one-cycle pulse when the last word of the last pass has been output.

Behaviour:
- Reset values: pat_data=0, pat_valid=0, busy=0, finished=0, wr_ptr=0, rd_ptr=0, reps_left=0, state=IDLE. Memory contents are undefined after reset and are not cleared.
- Reset mid-operation: state returns to IDLE at the next edge; the partial pass is discarded; finished is not pulsed.
- Loading:
  - A write is accepted only in IDLE; writes are ignored in any other state.
  - wr_ptr wraps at 2^PATTERN_DEPTH.
  - wr_ptr_reset wins over a simultaneous write; that write lands at the old wr_ptr and wr_ptr becomes 0.
- Length rules:
  - Effective length len = min(pattern_length, 2^PATTERN_DEPTH).
  - start_strobe with pattern_length=0 is ignored.
- States:
  - IDLE: pat_data<=idle_value, pat_valid<=0. On start_strobe: latch len and reps_left<=repeat_count, rd_ptr<=0. Go to ARMED if trigger_enable, else PLAY.
  - ARMED: pat_data holds idle_value. When external_trigger=1, go to PLAY. enable has no effect in ARMED.
  - PLAY, enable=1: pat_data<=mem[rd_ptr], pat_valid<=1.
    - If rd_ptr==len-1 and reps_left==0: go to DONE.
    - If rd_ptr==len-1 and reps_left!=0: rd_ptr<=0, reps_left--.
    - Otherwise rd_ptr++.
  - PLAY, enable=0: rd_ptr holds, pat_data holds, pat_valid<=0.
  - DONE: finished<=1 for exactly one cycle, pat_valid<=0, pat_data<=idle_value, then go to IDLE.
- stop_strobe:
  - In any non-IDLE state, the next state is IDLE and pat_valid<=0; finished is not pulsed.
  - stop_strobe and start_strobe together in IDLE: stop wins, start is ignored.
- Latency: start_strobe at edge N (no trigger) gives word 0 on pat_data after edge N+2, then one word per cycle with no gap across pass boundaries.
- Total words output = len*(repeat_count+1).
- A write in the same cycle as start_strobe is accepted and is visible to playback.
- Control inputs are sampled only at start; changes during playback have no effect.

Optional Feature:
- Macro PATTERN_GEN_LOOP_FOREVER_EN.
- Defined: repeat_count=32'hFFFFFFFF latched at start means loop indefinitely. reps_left never decrements, DONE is never reached, and only stop_strobe or rst ends playback.
- Undefined: 32'hFFFFFFFF is an ordinary count, giving 2^32 passes.

Test Plan:
- Load 4 words 0xA,0xB,0xC,0xD; pattern_length=4, repeat_count=0; start at edge N -> pat_valid=1 with pat_data 0xA..0xD after edges N+2..N+5; finished pulses one cycle after 0xD; pat_data then equals idle_value.
- Same 4 words with repeat_count=2 -> 12 consecutive valid words A,B,C,D x3 with no gaps; exactly one finished pulse.
- trigger_enable=1, start, hold external_trigger=0 for 20 cycles -> busy=1, pat_valid=0, pat_data=idle_value throughout; raise trigger -> 0xA appears two edges later.
- Mid-pass drop enable for 3 cycles after 0xB -> pat_valid=0 and pat_data=0xB during the pause; resume with 0xC; the word sequence is unbroken.
- stop_strobe after 0xB, and separately rst after 0xB -> IDLE next edge, pat_valid=0, no finished pulse; writes during PLAY are ignored (verify by readback playback).
- With PATTERN_GEN_LOOP_FOREVER_EN defined and repeat_count=0xFFFFFFFF -> pattern still looping after 1000 cycles, no finished pulse; stop_strobe -> IDLE.
